// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int unsigned ADC_W          = 12;
    localparam int unsigned TIMEOUT_CYCLES = 512;
    localparam int unsigned WD_W           = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        CONVERT   = 2'd2,
        PUBLISH   = 2'd3
    } state_e;

endpackage

// File: rtl/adc_sample_sched_tick.sv
// Sample-rate divider: counts 0..DIV-1 while enabled, tick_c on the terminal count.
module sample_tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Disable or clear holds the count at zero and suppresses the tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_c = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// Schedules dual-channel ADC conversions, box-car averages 2^AVG_LOG2 samples.
// Optional conversion watchdog and timeout_o port under ADC_SCHED_TIMEOUT_EN.
module adc_sample_sched
    import adc_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned SAMPLE_HZ = 1000,
    parameter int unsigned AVG_LOG2  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    output logic             adc_en_o,
    input  logic             adc_update_i,
    input  logic [ADC_W-1:0] adc_data0_i,
    input  logic [ADC_W-1:0] adc_data1_i,
    output logic [ADC_W-1:0] avg0_o,
    output logic [ADC_W-1:0] avg1_o,
    output logic             avg_valid_o,
    output logic             overrun_o,
    output logic             busy_o
`ifdef ADC_SCHED_TIMEOUT_EN
    ,
    output logic             timeout_o
`endif
);

    localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned ACC_W    = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1) << AVG_LOG2;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc0_q, acc0_d;
    logic [ACC_W-1:0] acc1_q, acc1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0] avg0_q, avg0_d;
    logic [ADC_W-1:0] avg1_q, avg1_d;
    logic             avg_valid_q, avg_valid_d;
    logic             adc_en_q, adc_en_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             tick_c;
`ifdef ADC_SCHED_TIMEOUT_EN
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
`endif

    // Held clear in IDLE so the first tick lands a full period after WAIT_TICK entry.
    sample_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (run_i),
        .clr_i  (state_q == IDLE),
        .tick_c (tick_c)
    );

    always_comb begin
        state_d     = state_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        cnt_d       = cnt_q;
        avg0_d      = avg0_q;
        avg1_d      = avg1_q;
        avg_valid_d = 1'b0;
        overrun_d   = overrun_q;
`ifdef ADC_SCHED_TIMEOUT_EN
        wd_d        = '0;
        timeout_d   = timeout_q;
`endif

        // A tick that cannot start a conversion is dropped and flagged.
        if (tick_c && (state_q == CONVERT || state_q == PUBLISH)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (run_i) begin
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!run_i) begin
                    state_d = IDLE;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    cnt_d   = '0;
                end else if (tick_c) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
`ifdef ADC_SCHED_TIMEOUT_EN
                wd_d = wd_q + WD_W'(1);
`endif
                if (adc_update_i) begin
                    acc0_d = acc0_q + ACC_W'(adc_data0_i);
                    acc1_d = acc1_q + ACC_W'(adc_data1_i);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_d == N_SAMPLES) begin
                        state_d = PUBLISH;
                    end else if (run_i) begin
                        state_d = WAIT_TICK;
                    end else begin
                        state_d = IDLE;
                        acc0_d  = '0;
                        acc1_d  = '0;
                        cnt_d   = '0;
                    end
                end
`ifdef ADC_SCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    wd_d      = '0;
                    if (run_i) begin
                        state_d = WAIT_TICK;
                    end else begin
                        state_d = IDLE;
                        acc0_d  = '0;
                        acc1_d  = '0;
                        cnt_d   = '0;
                    end
                end
`endif
            end
            PUBLISH: begin
                avg0_d      = ADC_W'(acc0_q >> AVG_LOG2);
                avg1_d      = ADC_W'(acc1_q >> AVG_LOG2);
                avg_valid_d = 1'b1;
                acc0_d      = '0;
                acc1_d      = '0;
                cnt_d       = '0;
                state_d     = run_i ? WAIT_TICK : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        adc_en_d = (state_d == CONVERT);
        busy_d   = (state_d == CONVERT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc0_q      <= '0;
            acc1_q      <= '0;
            cnt_q       <= '0;
            avg0_q      <= '0;
            avg1_q      <= '0;
            avg_valid_q <= 1'b0;
            adc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            cnt_q       <= cnt_d;
            avg0_q      <= avg0_d;
            avg1_q      <= avg1_d;
            avg_valid_q <= avg_valid_d;
            adc_en_q    <= adc_en_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef ADC_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign adc_en_o    = adc_en_q;
    assign busy_o      = busy_q;
    assign avg0_o      = avg0_q;
    assign avg1_o      = avg1_q;
    assign avg_valid_o = avg_valid_q;
    assign overrun_o   = overrun_q;
`ifdef ADC_SCHED_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`endif

endmodule

// File: tb/tb_adc_sample_sched.sv
// Bench for adc_sample_sched: averaging (AVG_LOG2=2) and pass-through (AVG_LOG2=0) instances.
module tb_adc_sample_sched;

    localparam int TICK_DIV = 64;
    localparam int N_AVG    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        run_pt = 1'b0;
    logic        adc_update = 1'b0;
    logic [11:0] d0 = '0;
    logic [11:0] d1 = '0;

    logic        en_m, valid_m, ovr_m, busy_m;
    logic [11:0] avg0_m, avg1_m;
    logic        en_p, valid_p, ovr_p, busy_p;
    logic [11:0] avg0_p, avg1_p;
`ifdef ADC_SCHED_TIMEOUT_EN
    logic        to_m, to_p;
`endif

    adc_sample_sched #(.CLK_HZ(6400), .SAMPLE_HZ(100), .AVG_LOG2(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .adc_en_o     (en_m),
        .adc_update_i (adc_update),
        .adc_data0_i  (d0),
        .adc_data1_i  (d1),
        .avg0_o       (avg0_m),
        .avg1_o       (avg1_m),
        .avg_valid_o  (valid_m),
        .overrun_o    (ovr_m),
        .busy_o       (busy_m)
`ifdef ADC_SCHED_TIMEOUT_EN
        ,.timeout_o   (to_m)
`endif
    );

    adc_sample_sched #(.CLK_HZ(6400), .SAMPLE_HZ(100), .AVG_LOG2(0)) dut_pt (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_pt),
        .adc_en_o     (en_p),
        .adc_update_i (adc_update),
        .adc_data0_i  (d0),
        .adc_data1_i  (d1),
        .avg0_o       (avg0_p),
        .avg1_o       (avg1_p),
        .avg_valid_o  (valid_p),
        .overrun_o    (ovr_p),
        .busy_o       (busy_p)
`ifdef ADC_SCHED_TIMEOUT_EN
        ,.timeout_o   (to_p)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;

    // Reference model: samples of the open averaging group, expected publish cycle and values.
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int          pub_m = -1, pub_p = -1;
    logic [11:0] ea0_m = '0, ea1_m = '0, na0_m = '0, na1_m = '0;
    logic [11:0] ea0_p = '0, ea1_p = '0, na0_p = '0, na1_p = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic en_of(input bit pt);
        return pt ? en_p : en_m;
    endfunction

    function automatic logic busy_of(input bit pt);
        return pt ? busy_p : busy_m;
    endfunction

    // One clock; strobes must appear exactly when predicted and averages hold otherwise.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("valid_m", valid_m, cyc == pub_m);
        if (cyc == pub_m) begin
            ea0_m = na0_m;
            ea1_m = na1_m;
        end
        chk("avg0_m", avg0_m, ea0_m);
        chk("avg1_m", avg1_m, ea1_m);
        chk("valid_p", valid_p, cyc == pub_p);
        if (cyc == pub_p) begin
            ea0_p = na0_p;
            ea1_p = na1_p;
        end
        chk("avg0_p", avg0_p, ea0_p);
        chk("avg1_p", avg1_p, ea1_p);
    endtask

    task automatic wait_en(input bit pt, input int ref_cyc, input int exp_lat);
        int n = 0;
        while (en_of(pt) !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("en_rise_seen", en_of(pt), 1);
        chk("en_rise_latency", cyc - ref_cyc, exp_lat);
        last_rise = cyc;
    endtask

    // ADC answers after 'delay' cycles; the model decides whether a publish follows.
    task automatic respond(input bit pt, input logic [11:0] a, input logic [11:0] b,
                           input int delay, input bit discard);
        int s0, s1;
        for (int i = 0; i < delay; i++) begin
            step();
            chk("en_hold", en_of(pt), 1);
            chk("busy_hold", busy_of(pt), 1);
        end
        adc_update = 1'b1;
        d0 = a;
        d1 = b;
        if (pt) begin
            na0_p = a;
            na1_p = b;
            pub_p = cyc + 2;
        end else begin
            q0.push_back(a);
            q1.push_back(b);
            if (discard) begin
                q0.delete();
                q1.delete();
            end else if (q0.size() == N_AVG) begin
                s0 = 0;
                s1 = 0;
                foreach (q0[i]) begin
                    s0 += int'(q0[i]);
                    s1 += int'(q1[i]);
                end
                na0_m = 12'(s0 / N_AVG);
                na1_m = 12'(s1 / N_AVG);
                pub_m = cyc + 2;
                q0.delete();
                q1.delete();
            end
        end
        step();
        adc_update = 1'b0;
        d0 = 12'($urandom);
        d1 = 12'($urandom);
        chk("en_drop", en_of(pt), 0);
        chk("busy_drop", busy_of(pt), 0);
    endtask

    task automatic main_group(input int ref_cyc, input int first_lat, input bit directed);
        logic [11:0] a, b;
        int dl, r, lat;
        r = ref_cyc;
        for (int i = 0; i < N_AVG; i++) begin
            if (directed) begin
                a  = 12'(100 * (i + 1));
                b  = 12'hFFF;
                dl = i * 7;
            end else begin
                a  = 12'($urandom);
                b  = 12'($urandom);
                dl = int'($urandom_range(0, 40));
            end
            lat = (i == 0) ? first_lat : TICK_DIV;
            wait_en(1'b0, r, lat);
            respond(1'b0, a, b, dl, 1'b0);
            r = last_rise;
        end
    endtask

    initial begin
        int  rc, k;
        bit  seen;

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_en", en_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_avg0", avg0_m, 0);
        chk("rst_avg1", avg1_m, 0);
        chk("rst_ovr", ovr_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_pt_en", en_p, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("idle_en", en_m, 0);

        // Directed average: 100..400 and 4095 give 250 / 4095.
        run = 1'b1;
        rc  = cyc;
        main_group(rc, TICK_DIV + 1, 1'b1);
        chk("model_avg0_directed", na0_m, 250);
        main_group(last_rise, TICK_DIV, 1'b0);
        main_group(last_rise, TICK_DIV, 1'b0);

        // Stop during the second conversion of a group: completes, then discarded.
        wait_en(1'b0, last_rise, TICK_DIV);
        respond(1'b0, 12'($urandom), 12'($urandom), 4, 1'b0);
        wait_en(1'b0, last_rise, TICK_DIV);
        run = 1'b0;
        respond(1'b0, 12'($urandom), 12'($urandom), 5, 1'b1);
        seen = 1'b0;
        repeat (130) begin
            step();
            if (en_m) seen = 1'b1;
        end
        chk("stop_no_en", seen, 0);
        run = 1'b1;
        rc  = cyc;
        main_group(rc, TICK_DIV + 1, 1'b0);

        // Overrun: ADC stalls past the next tick; that tick is dropped.
        chk("ovr_clear", ovr_m, 0);
        wait_en(1'b0, last_rise, TICK_DIV);
        k = last_rise;
        for (int i = 0; i < 70; i++) begin
            step();
            chk("stall_en", en_m, 1);
            if (cyc == k + TICK_DIV - 1) chk("ovr_before_tick", ovr_m, 0);
            if (cyc == k + TICK_DIV) chk("ovr_after_tick", ovr_m, 1);
        end
        respond(1'b0, 12'($urandom), 12'($urandom), 0, 1'b0);
        wait_en(1'b0, k, 2 * TICK_DIV);
        chk("ovr_sticky", ovr_m, 1);

        // Reset in the middle of a conversion.
        repeat (3) step();
        chk("pre_rst_busy", busy_m, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", en_m, 0);
        chk("mid_rst_valid", valid_m, 0);
        chk("mid_rst_avg0", avg0_m, 0);
        chk("mid_rst_avg1", avg1_m, 0);
        chk("mid_rst_ovr", ovr_m, 0);
        chk("mid_rst_busy", busy_m, 0);
        q0.delete();
        q1.delete();
        ea0_m = '0;
        ea1_m = '0;
        pub_m = -1;
        run = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (150) begin
            step();
            if (en_m) seen = 1'b1;
        end
        chk("post_rst_no_en", seen, 0);
        run = 1'b1;
        rc  = cyc;
        main_group(rc, TICK_DIV + 1, 1'b0);

        // Pass-through instance: one publish per conversion.
        run = 1'b0;
        repeat (5) step();
        run_pt = 1'b1;
        rc = cyc;
        for (int i = 0; i < 5; i++) begin
            wait_en(1'b1, (i == 0) ? rc : last_rise, (i == 0) ? TICK_DIV + 1 : TICK_DIV);
            respond(1'b1, (i < 3) ? 12'hABC : 12'($urandom), 12'($urandom),
                    int'($urandom_range(0, 40)), 1'b0);
        end
        repeat (4) step();
        chk("pt_avg0_last", avg0_p, na0_p);
        run_pt = 1'b0;
        repeat (5) step();

`ifdef ADC_SCHED_TIMEOUT_EN
        // Silent ADC: watchdog drops the enable after 512 cycles and re-arms.
        run = 1'b1;
        rc  = cyc;
        wait_en(1'b0, rc, TICK_DIV + 1);
        k = last_rise;
        chk("to_clear", to_m, 0);
        begin
            int n = 0;
            while (en_m === 1'b1 && n < 700) begin
                step();
                n++;
            end
            chk("to_en_cycles", n, 512);
        end
        chk("to_set", to_m, 1);
        wait_en(1'b0, k, 9 * TICK_DIV);
        respond(1'b0, 12'($urandom), 12'($urandom), 3, 1'b0);
        repeat (10) step();
        chk("to_sticky", to_m, 1);
        run = 1'b0;
        repeat (3) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
